result_serial_reader: RTL and testbench
=======================================

// Module: result_serial_reader
// PURPOSE
//  Reads a held ALU result word out of storage and sends it one bit per beat over a serial valid/ready link.
//  - Load side: one-word capture handshake.
//  - Output side: bit stream framed by ser_last.
//  - Placement: after the result storage cells, before any bit-serial consumer (debug port, off-chip link).
// PARAMETERS
//  WIDTH      8  bits per word, legal range >= 2
//  MSB_FIRST  1  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//  ODD_PAR    0  parity sense when PARITY_EN is defined; 0 = even, 1 = odd
// PORTS
//  clk         in   1                  rising-edge clock
//  reset       in   1                  synchronous, active-high
//  load_valid  in   1                  load_data is valid
//  load_ready  out  1                  block can accept a word
//  load_data   in   WIDTH              word to serialise
//  ser_valid   out  1                  ser_bit is valid
//  ser_ready   in   1                  consumer accepts the current beat
//  ser_bit     out  1                  current serial bit
//  ser_last    out  1                  current beat is the final beat of the frame
//  busy        out  1                  a frame is in progress (state != IDLE)
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-high on reset.
//  - Reset values: state=IDLE, shift reg=0, count=0, ser_valid=0, ser_bit=0, ser_last=0, busy=0.
//  - load_ready = (state==IDLE) & ~reset, so it reads 1 from the first cycle after reset.
//  - States:
//    - IDLE: load_ready=1. load_valid & load_ready captures load_data and clears count; the next state is SHIFT.
//    - SHIFT: ser_valid=1. ser_bit = current bit in the order set by MSB_FIRST. A beat advances only on ser_valid & ser_ready.
//      - On the accepted beat where count==WIDTH-1: go to PARITY if PARITY_EN is defined, else go to IDLE.
//    - PARITY (only when PARITY_EN is defined): ser_valid=1, ser_bit = parity of the captured word, ser_last=1. When accepted, go to IDLE.
//  - Latency: a load accepted in cycle N gives the first valid bit in cycle N+1.
//  - Frame spacing: at least one IDLE cycle between frames. Continuous ser_ready gives WIDTH (+1 with parity) consecutive beats.
//  - Stall: while ser_valid & ~ser_ready, ser_bit and ser_last hold their values and count is frozen.
//  - ser_last: high only on the final beat, which is the last data bit without parity or the parity beat with parity.
//  - load_valid while busy: ignored, because load_ready=0. The frame in flight is not affected.
//  - Reset mid-frame: the frame is aborted. In the next cycle state is IDLE and ser_valid=0. No ser_last is issued.
//  - count is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
//  - Parity = ^captured_word ^ ODD_PAR. It is computed from the captured copy, not from live load_data.
// CONFIGURATION
//  - Macro RESULT_SERIAL_PARITY_EN:
//    - Defined: the PARITY state exists and every frame is WIDTH+1 beats.
//    - Undefined: the PARITY state and parity logic are absent, ODD_PAR is unused, and frames are WIDTH beats.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - typedef enum ser_state_t {IDLE, SHIFT, PARITY}
//    - localparam PAR_EVEN=0 and PAR_ODD=1
//  - One sub-module, parity_gen (WIDTH in, 1 bit out, combinational XOR tree), is used only under RESULT_SERIAL_PARITY_EN.
//  - All other logic (state register, shift register, counter) lives inline.
// TESTING (WIDTH=8)
//  - MSB_FIRST=1, load 8'hA5, ser_ready=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_last on beat 8; with parity, beat 9 = 0 (even) with ser_last.
//  - MSB_FIRST=0, load 8'h01 -> beat 1 = 1, beats 2-8 = 0; busy low 1 cycle after the last beat is accepted.
//  - Load 8'hA5, ser_ready low for 3 cycles after beat 2 -> ser_bit stays 0 and ser_valid stays 1 for 3 cycles; stream then resumes with 1,0,0,1,0,1.
//  - load_valid=1 with 8'hFF during the SHIFT of 8'h3C -> load_ready=0, 8'h3C stream intact, 8'hFF never captured.
//  - Assert reset after 3 accepted beats -> next cycle ser_valid=0, busy=0, ser_last=0; one cycle after reset deasserts, load_ready=1.
//  - RESULT_SERIAL_PARITY_EN with ODD_PAR=1, load 8'h07 -> parity beat = 0 with ser_last=1; 9 beats total.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the result serial reader: FSM state encoding and parity-sense values.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } ser_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/result_serial_reader_parity_gen.sv
// Combinational XOR-reduction parity of one word; instantiated only when RESULT_SERIAL_PARITY_EN is defined.
module parity_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/result_serial_reader.sv
// Serialises a captured result word one bit per valid/ready beat, framing the stream with ser_last.
// Optional trailing parity beat is enabled by defining RESULT_SERIAL_PARITY_EN.
module result_serial_reader
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int ODD_PAR   = PAR_EVEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef RESULT_SERIAL_PARITY_EN
  localparam bit HAS_PARITY = 1'b1;
`else
  localparam bit HAS_PARITY = 1'b0;
`endif

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rot_word;
  logic             beat_accept;
  logic             par_bit;

  // Bit that goes on the wire first for a given word orientation.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Rotating (not shifting) leaves the captured word intact after a full frame.
  always_comb begin
    rot_word = shreg;
    if (MSB_FIRST != 0) rot_word = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
    else                rot_word = {shreg[0], shreg[WIDTH-1:1]};
  end

  assign beat_accept = ser_valid & ser_ready;
  assign load_ready  = (state == IDLE) & ~reset;

`ifdef RESULT_SERIAL_PARITY_EN
  logic word_par;

  parity_gen #(.WIDTH(WIDTH)) u_parity_gen (
    .data   (shreg),
    .parity (word_par)
  );

  assign par_bit = word_par ^ (ODD_PAR == PAR_ODD);
`else
  logic unused_odd_par;
  assign unused_odd_par = (ODD_PAR == PAR_ODD);
  assign par_bit        = 1'b0;
`endif

  // NOTE: every register here uses <= so all updates see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      count     <= '0;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            shreg     <= load_data;
            count     <= '0;
            state     <= SHIFT;
            ser_valid <= 1'b1;
            ser_bit   <= head_bit(load_data);
            ser_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        SHIFT: begin
          if (beat_accept) begin
            shreg <= rot_word;
            if (count == LAST_IDX) begin
              if (HAS_PARITY) begin
                state    <= PARITY;
                ser_bit  <= par_bit;
                ser_last <= 1'b1;
              end else begin
                state     <= IDLE;
                ser_valid <= 1'b0;
                ser_bit   <= 1'b0;
                ser_last  <= 1'b0;
                busy      <= 1'b0;
              end
            end else begin
              count    <= count + 1'b1;
              ser_bit  <= head_bit(rot_word);
              ser_last <= !HAS_PARITY && (count == LAST_IDX - 1'b1);
            end
          end
        end

        PARITY: begin
          if (beat_accept) begin
            state     <= IDLE;
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_serial_reader.sv
// Directed self-checking bench for result_serial_reader: an MSB-first even-parity instance and an
// LSB-first odd-parity instance, with frame length following RESULT_SERIAL_PARITY_EN.
module tb_result_serial_reader;

`ifdef RESULT_SERIAL_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk;
  logic       reset;
  logic       load_valid [2];
  logic       load_ready [2];
  logic [7:0] load_data  [2];
  logic       ser_valid  [2];
  logic       ser_ready  [2];
  logic       ser_bit    [2];
  logic       ser_last   [2];
  logic       busy       [2];

  int n_checks;
  int n_fail;

  result_serial_reader #(.WIDTH(8), .MSB_FIRST(1), .ODD_PAR(0)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid[0]),
    .load_ready (load_ready[0]),
    .load_data  (load_data[0]),
    .ser_valid  (ser_valid[0]),
    .ser_ready  (ser_ready[0]),
    .ser_bit    (ser_bit[0]),
    .ser_last   (ser_last[0]),
    .busy       (busy[0])
  );

  result_serial_reader #(.WIDTH(8), .MSB_FIRST(0), .ODD_PAR(1)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid[1]),
    .load_ready (load_ready[1]),
    .load_data  (load_data[1]),
    .ser_valid  (ser_valid[1]),
    .ser_ready  (ser_ready[1]),
    .ser_bit    (ser_bit[1]),
    .ser_last   (ser_last[1]),
    .busy       (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Loads one word into instance u and follows the whole frame; starts and ends on a falling edge.
  // stall_beat >= 0 drops ser_ready for stall_len cycles while that beat is presented.
  // junk=1 holds load_valid with 8'hFF during the frame, which must be ignored.
  task automatic send(input int u, input logic [7:0] w, input int stall_beat,
                      input int stall_len, input bit junk);
    logic eb;
    logic el;
    check("load_ready_idle", 32'(load_ready[u]), 32'd1);
    load_data[u]  = w;
    load_valid[u] = 1'b1;
    ser_ready[u]  = 1'b1;
    @(negedge clk);
    load_valid[u] = 1'b0;
    check("busy_start", 32'(busy[u]), 32'd1);
    for (int beat = 0; beat < NB; beat++) begin
      if (beat < 8) eb = (u == 0) ? w[7-beat] : w[beat];
      else          eb = (^w) ^ (u == 1);
      el = (beat == NB - 1);
      check($sformatf("u%0d_valid_b%0d", u, beat), 32'(ser_valid[u]), 32'd1);
      check($sformatf("u%0d_bit_b%0d", u, beat), 32'(ser_bit[u]), 32'(eb));
      check($sformatf("u%0d_last_b%0d", u, beat), 32'(ser_last[u]), 32'(el));
      if (junk) begin
        check("load_ready_busy", 32'(load_ready[u]), 32'd0);
        load_data[u]  = 8'hFF;
        load_valid[u] = (beat != NB - 1);
      end
      if (beat == stall_beat) begin
        ser_ready[u] = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check("stall_valid", 32'(ser_valid[u]), 32'd1);
          check("stall_bit", 32'(ser_bit[u]), 32'(eb));
          check("stall_last", 32'(ser_last[u]), 32'(el));
        end
        ser_ready[u] = 1'b1;
      end
      @(negedge clk);
    end
    load_valid[u] = 1'b0;
    check("end_busy", 32'(busy[u]), 32'd0);
    check("end_valid", 32'(ser_valid[u]), 32'd0);
    check("end_last", 32'(ser_last[u]), 32'd0);
    check("end_load_ready", 32'(load_ready[u]), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    for (int u = 0; u < 2; u++) begin
      load_valid[u] = 1'b0;
      load_data[u]  = 8'h00;
      ser_ready[u]  = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(ser_valid[0]), 32'd0);
    check("rst_bit", 32'(ser_bit[0]), 32'd0);
    check("rst_last", 32'(ser_last[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_load_ready", 32'(load_ready[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_load_ready", 32'(load_ready[0]), 32'd1);
    check("post_rst_load_ready_lsb", 32'(load_ready[1]), 32'd1);

    send(0, 8'hA5, -1, 0, 1'b0);  // MSB-first 1,0,1,0,0,1,0,1
    send(1, 8'h01, -1, 0, 1'b0);  // LSB-first 1 then zeros
    send(0, 8'hA5, 1, 3, 1'b0);   // stall holding the second beat (0)
    send(0, 8'h3C, -1, 0, 1'b1);  // load attempt while busy
    send(1, 8'h07, -1, 0, 1'b0);  // odd parity of 07 is 0

    // Abort a frame after three accepted beats.
    load_data[0]  = 8'h5A;
    load_valid[0] = 1'b1;
    ser_ready[0]  = 1'b1;
    @(negedge clk);
    load_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_valid", 32'(ser_valid[0]), 32'd1);
    check("pre_abort_bit", 32'(ser_bit[0]), 32'd1);  // beat 4 of 5A is bit 4 = 1
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(ser_valid[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_last", 32'(ser_last[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_load_ready", 32'(load_ready[0]), 32'd1);

    send(0, 8'h81, -1, 0, 1'b0);  // clean frame after abort

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
